// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare conditional-branch predictor with speculative global history
//
// Purpose:
//   Predicts RV32 B-type and compressed C.BEQZ/C.BNEZ branches for the fetcher.
//   A table of 2**IDX_W saturating counters is indexed by PC XOR the global
//   history register (GHR). The lookup is purely combinational. Each prediction
//   carries the GHR snapshot it used, and the ROB returns that snapshot at commit.
//   The commit side uses the snapshot to train the counters and to restore the
//   GHR after a mispredict.
//
// Configuration:
//   BP_GSHARE_EN defined   : full gshare (history XOR-ed into the index, speculative GHR).
//   BP_GSHARE_EN undefined : bimodal mode. The GHR is constant 0 and pred_ghr is 0.
//                            The index is the PC bits only.
//
// Ports:
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   rdy_in                    global ready; low freezes GHR and counters
//   q_valid/q_ins/q_pc/q_is32 fetch lookup request
//   pred_taken/pred_pc        prediction and next fetch PC (same cycle)
//   pred_ghr                  history snapshot used for this lookup
//   upd_valid/upd_pc/upd_taken/upd_ghr/upd_mispred
//                             commit-time training and recovery

module gshare_predictor #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 2,
    parameter int GHR_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             q_valid,
    input  logic [31:0]      q_ins,
    input  logic [31:0]      q_pc,
    input  logic             q_is32,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispred
);

    localparam int ENTRIES = 1 << IDX_W;
    // Weakly not-taken: the largest value whose MSB is still 0.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0] cnt_tbl [ENTRIES];
    logic [GHR_W-1:0] ghr;

    logic             is_b32;
    logic             is_cb;
    logic             is_branch;
    logic [31:0]      imm_b;
    logic [31:0]      imm_cb;
    logic [31:0]      seq_pc;
    logic [31:0]      tgt_pc;
    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] upd_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Instruction bits that never take part in decode or immediate extraction.
    logic unused_in;
    assign unused_in = &{1'b0, q_ins[24:16], q_ins[13], upd_pc[31:IDX_W+1], upd_pc[0]};

    //--------------------------------------------------------------------
    // Decode and target arithmetic
    //--------------------------------------------------------------------
    always_comb begin
        is_b32 = q_is32 && (q_ins[6:0] == 7'b1100011);
        // funct3 110/111 on quadrant 1 are C.BEQZ/C.BNEZ, so bit 13 does not matter.
        is_cb = !q_is32 && (q_ins[1:0] == 2'b01) && (q_ins[15:14] == 2'b11);
        is_branch = is_b32 || is_cb;
        imm_b = {{19{q_ins[31]}}, q_ins[31], q_ins[7], q_ins[30:25], q_ins[11:8], 1'b0};
        imm_cb = {{23{q_ins[12]}}, q_ins[12], q_ins[6:5], q_ins[2], q_ins[11:10],
                  q_ins[4:3], 1'b0};
        seq_pc = q_pc + (q_is32 ? 32'd4 : 32'd2);
        tgt_pc = q_pc + (q_is32 ? imm_b : imm_cb);
    end

    //--------------------------------------------------------------------
    // Table indexing
    //--------------------------------------------------------------------
`ifdef BP_GSHARE_EN
    // The history occupies the low bits of the index; the upper bits are pure PC.
    assign lkp_idx = q_pc[IDX_W:1] ^ IDX_W'(ghr);
    assign upd_idx = upd_pc[IDX_W:1] ^ IDX_W'(upd_ghr);
`else
    logic unused_ghr_in;
    assign unused_ghr_in = &{1'b0, upd_ghr, upd_mispred};
    assign lkp_idx = q_pc[IDX_W:1];
    assign upd_idx = upd_pc[IDX_W:1];
`endif

    //--------------------------------------------------------------------
    // Prediction outputs
    //--------------------------------------------------------------------
    // Read the table before the clock edge, so a lookup that hits an entry
    // being trained in the same cycle sees the old counter value.
    assign pred_taken = q_valid && is_branch && cnt_tbl[lkp_idx][CNT_W-1];
    assign pred_pc    = pred_taken ? tgt_pc : seq_pc;
    assign pred_ghr   = ghr;

    //--------------------------------------------------------------------
    // Counter training
    //--------------------------------------------------------------------
    always_comb begin
        upd_cnt  = cnt_tbl[upd_idx];
        cnt_next = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != {CNT_W{1'b1}}) begin
                cnt_next = upd_cnt + 1'b1;
            end
        end else begin
            if (upd_cnt != {CNT_W{1'b0}}) begin
                cnt_next = upd_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_tbl[i] <= CNT_INIT;
            end
        end else if (rdy_in && upd_valid) begin
            cnt_tbl[upd_idx] <= cnt_next;
        end
    end

    //--------------------------------------------------------------------
    // Speculative global history
    //--------------------------------------------------------------------
`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_next;

    // The size cast drops the oldest bit after the one-bit shift. It also
    // covers GHR_W == 1, where the register just holds the newest outcome.
    always_comb begin
        ghr_next = ghr;
        if (upd_valid && upd_mispred) begin
            // Recovery wins: the flushed same-cycle lookup must not shift in.
            ghr_next = GHR_W'({upd_ghr, upd_taken});
        end else if (q_valid && is_branch) begin
            ghr_next = GHR_W'({ghr, pred_taken});
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ghr <= '0;
        end else if (rdy_in) begin
            ghr <= ghr_next;
        end
    end
`else
    assign ghr = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - table-driven bench for gshare_predictor

module tb_gshare_predictor;

`ifdef BP_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    localparam logic [31:0] BEQ16 = 32'h0000_0863;
    localparam logic [31:0] BNEM4 = 32'hFE00_1EE3;
    localparam logic [31:0] CBNEZ = 32'hABCD_FC65;
    localparam logic [31:0] ADDI  = 32'h0000_0013;
    localparam logic [31:0] CJ    = 32'h0000_A001;
    localparam logic [31:0] CB32  = 32'h0000_C001;
    localparam logic [31:0] SPC   = GS ? 32'h102 : 32'h100;
    localparam logic [31:0] PPC   = GS ? 32'h106 : 32'h100;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, q_valid, q_is32;
    logic [31:0] q_ins, q_pc, pred_pc, upd_pc;
    logic        pred_taken, upd_valid, upd_taken, upd_mispred;
    logic [7:0]  pred_ghr, upd_ghr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    gshare_predictor dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .q_valid     (q_valid),
        .q_ins       (q_ins),
        .q_pc        (q_pc),
        .q_is32      (q_is32),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .pred_ghr    (pred_ghr),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_ghr     (upd_ghr),
        .upd_mispred (upd_mispred)
    );

    typedef struct {
        logic        rst_n, rdy, qv;
        logic [31:0] ins, pc;
        logic        is32, uv;
        logic [31:0] upc;
        logic        ut;
        logic [7:0]  ug;
        logic        um, chk, et;
        logic [31:0] epc;
        logic [7:0]  eg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t r(logic rst_n, logic rdy, logic qv, logic [31:0] ins,
                               logic [31:0] pc, logic is32, logic uv, logic [31:0] upc,
                               logic ut, logic [7:0] ug, logic um, logic chk,
                               logic et, logic [31:0] epc, logic [7:0] eg);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.qv = qv; v.ins = ins; v.pc = pc; v.is32 = is32;
        v.uv = uv; v.upc = upc; v.ut = ut; v.ug = ug; v.um = um;
        v.chk = chk; v.et = et; v.epc = epc; v.eg = eg;
        return v;
    endfunction

    // Frozen lookup: rdy_in low keeps state, outputs still follow inputs.
    function automatic vec_t probe(logic [31:0] ins, logic [31:0] pc, logic is32,
                                   logic et, logic [31:0] epc, logic [7:0] eg);
        return r(1, 0, 1, ins, pc, is32, 0, 0, 0, 8'h00, 0, 1, et, epc, eg);
    endfunction

    function automatic vec_t train(logic [31:0] upc, logic ut, logic [7:0] ug, logic [7:0] eg);
        return r(1, 1, 0, 0, 0, 1, 1, upc, ut, ug, 0, 1, 0, 32'h4, eg);
    endfunction

    function automatic logic [7:0] g(logic [7:0] x);
        return GS ? x : 8'h00;
    endfunction

    task automatic drive(logic rst_n, logic rdy, logic qv, logic [31:0] ins, logic [31:0] pc,
                         logic is32, logic uv, logic [31:0] upc, logic ut, logic [7:0] ug,
                         logic um);
        rst_n_in = rst_n; rdy_in = rdy; q_valid = qv; q_ins = ins; q_pc = pc; q_is32 = is32;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_ghr = ug; upd_mispred = um;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);

        // Reset with a commit present: the commit must be ignored.
        tbl.push_back(r(0, 1, 1, BEQ16, 32'h100, 1, 1, 32'h100, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, 1, 1, BEQ16, 32'h100, 1, 0, 0, 0, 8'h00, 0, 1, 0, 32'h104, 8'h00));
        tbl.push_back(r(1, 1, 0, BEQ16, 32'h100, 1, 1, 32'h100, 1, 8'h00, 0, 1, 0, 32'h104, 8'h00));
        tbl.push_back(r(1, 1, 0, BEQ16, 32'h100, 1, 1, 32'h100, 1, 8'h00, 0, 1, 0, 32'h104, 8'h00));
        // Counter is 11; rdy_in low blocks the commit and the speculative shift.
        tbl.push_back(r(1, 0, 1, BEQ16, 32'h100, 1, 1, 32'h100, 0, 8'h00, 0, 1, 1, 32'h110, 8'h00));
        tbl.push_back(r(1, 0, 1, BEQ16, 32'h100, 1, 1, 32'h100, 1, 8'h55, 1, 1, 1, 32'h110, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h300, 1, 1, 32'h310, 8'h00));
        // Walk the counter down to 00; it must not wrap.
        tbl.push_back(train(32'h100, 0, 8'h00, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h100, 1, 1, 32'h110, 8'h00));
        tbl.push_back(train(32'h100, 0, 8'h00, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h100, 1, 0, 32'h104, 8'h00));
        tbl.push_back(train(32'h100, 0, 8'h00, 8'h00));
        tbl.push_back(train(32'h100, 0, 8'h00, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h100, 1, 0, 32'h104, 8'h00));
        tbl.push_back(train(32'h100, 1, 8'h00, 8'h00));
        tbl.push_back(train(32'h100, 1, 8'h00, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h100, 1, 1, 32'h110, 8'h00));
        // Compressed branch, negative targets, non-branch decode and PC wrap.
        tbl.push_back(probe(CBNEZ, 32'h200, 0, 0, 32'h202, 8'h00));
        tbl.push_back(train(32'h200, 1, 8'h00, 8'h00));
        tbl.push_back(probe(CBNEZ, 32'h200, 0, 1, 32'h1F8, 8'h00));
        tbl.push_back(probe(BNEM4, 32'h400, 1, 1, 32'h3FC, 8'h00));
        tbl.push_back(probe(ADDI, 32'h200, 1, 0, 32'h204, 8'h00));
        tbl.push_back(probe(CJ, 32'h200, 0, 0, 32'h202, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h200, 0, 0, 32'h202, 8'h00));
        tbl.push_back(probe(CB32, 32'h200, 1, 0, 32'h204, 8'h00));
        tbl.push_back(probe(ADDI, 32'hFFFF_FFFC, 1, 0, 32'h0, 8'h00));
        tbl.push_back(probe(CBNEZ, 32'hFFFF_FFFE, 0, 0, 32'h0, 8'h00));
        // History: three taken lookups, then recovery with a same-cycle lookup.
        tbl.push_back(r(1, 1, 1, BEQ16, 32'h100, 1, 0, 0, 0, 8'h00, 0, 1, 1, 32'h110, 8'h00));
        tbl.push_back(r(1, 1, 1, BEQ16, 32'h102, 1, 0, 0, 0, 8'h00, 0, 1,
                        GS, GS ? 32'h112 : 32'h106, g(8'h01)));
        tbl.push_back(r(1, 1, 1, BEQ16, 32'h106, 1, 0, 0, 0, 8'h00, 0, 1,
                        GS, GS ? 32'h116 : 32'h10A, g(8'h03)));
        tbl.push_back(r(1, 1, 1, BEQ16, 32'h100, 1, 1, 32'h1FE, 0, 8'h05, 1, 1,
                        !GS, GS ? 32'h104 : 32'h110, g(8'h07)));
        tbl.push_back(probe(BEQ16, 32'h100, 1, !GS, GS ? 32'h104 : 32'h110, g(8'h0A)));
        // A correct-path commit leaves the history alone; recovery drops the old MSB.
        tbl.push_back(r(1, 1, 0, 0, 0, 1, 1, 32'h1FE, 1, 8'h0A, 0, 1, 0, 32'h4, g(8'h0A)));
        tbl.push_back(r(1, 1, 0, 0, 0, 1, 1, 32'h1FE, 1, 8'h80, 1, 1, 0, 32'h4, g(8'h0A)));
        // Lookup and training of the same entry: the lookup sees the old counter.
        tbl.push_back(r(1, 1, 1, BEQ16, SPC, 1, 1, SPC, 0, 8'h01, 0, 1, 1, SPC + 32'd16, g(8'h01)));
        tbl.push_back(probe(BEQ16, PPC, 1, 0, PPC + 32'd4, g(8'h03)));
        // Reset while frozen still clears everything.
        tbl.push_back(r(0, 0, 1, BEQ16, 32'h100, 1, 1, 32'h200, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(probe(CBNEZ, 32'h200, 0, 0, 32'h202, 8'h00));
        tbl.push_back(probe(BEQ16, 32'h100, 1, 0, 32'h104, 8'h00));

        foreach (tbl[i]) begin
            @(negedge clk_in);
            drive(tbl[i].rst_n, tbl[i].rdy, tbl[i].qv, tbl[i].ins, tbl[i].pc, tbl[i].is32,
                  tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].ug, tbl[i].um);
            #1;
            if (tbl[i].chk) begin
                check($sformatf("row%0d pred_taken", i), 32'(pred_taken), 32'(tbl[i].et));
                check($sformatf("row%0d pred_pc", i), pred_pc, tbl[i].epc);
                check($sformatf("row%0d pred_ghr", i), 32'(pred_ghr), 32'(tbl[i].eg));
            end
        end

        // Saturation at the top, then step back down through the MSB boundary.
        @(negedge clk_in);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
        repeat (3) begin
            @(negedge clk_in);
            drive(1, 1, 0, 0, 0, 1, 1, 32'h100, 1, 8'h00, 0);
        end
        @(negedge clk_in);
        drive(1, 0, 1, BEQ16, 32'h100, 1, 0, 0, 0, 8'h00, 0);
        #1 check("sat_top pred_pc", pred_pc, 32'h110);
        @(negedge clk_in);
        drive(1, 1, 0, 0, 0, 1, 1, 32'h100, 0, 8'h00, 0);
        @(negedge clk_in);
        drive(1, 0, 1, BEQ16, 32'h100, 1, 0, 0, 0, 8'h00, 0);
        #1 check("one_nt pred_taken", 32'(pred_taken), 32'd1);
        @(negedge clk_in);
        drive(1, 1, 0, 0, 0, 1, 1, 32'h100, 0, 8'h00, 0);
        @(negedge clk_in);
        drive(1, 0, 1, BEQ16, 32'h100, 1, 0, 0, 0, 8'h00, 0);
        #1 check("two_nt pred_taken", 32'(pred_taken), 32'd0);
        check("two_nt pred_pc", pred_pc, 32'h104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
